sd_prog: RTL and testbench
==========================

# sd_prog

Parametrised serial sequence detector for the sequence-detection family. It samples a 1-bit stream qualified by `data_valid` and compares it against a runtime-loadable pattern of `PAT_W` bits. It emits a one-cycle `match` pulse, with overlapping or non-overlapping detection selectable at runtime. An optional saturating match counter can be compiled in. It sits directly behind a serial data source and drives event or interrupt logic.

## Interface
- `PAT_W`, 4: pattern length in bits; legal range 2..32.
- `PAT_INIT`, 4'b0110: pattern loaded at reset; first-received bit is MSB.
- `CNT_W`, 8: width of `match_cnt`.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data`  in  1  serial input bit.
- `data_valid`  in  1  `data` is sampled only when high.
- `overlap_en`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `pat_load`  in  1  load `pat_in` into the pattern register.
- `pat_in`  in  PAT_W  new pattern.
- `cnt_clr`  in  1  synchronous clear of `match_cnt`.
- `match`  out  1  registered one-cycle detection pulse.
- `match_cnt`  out  CNT_W  saturating count of matches.

## Operation
- Registers:
  - `pat_reg[PAT_W-1:0]`
  - history shift register `hist[PAT_W-1:0]`
  - fill counter `fill` of width clog2(PAT_W+1), counting 0..PAT_W
  - `match`
  - `match_cnt`
- FSM is encoded by `fill`:
  - EMPTY (fill=0): no valid history.
  - FILLING (0<fill<PAT_W): history is still being collected.
  - ARMED (fill=PAT_W): every accepted bit is compared against the pattern.
- Accepted bit: `data_valid`=1 and `pat_load`=0. On each accepted bit:
  - `hist <= {hist[PAT_W-2:0], data}`.
  - `fill` increments and saturates at PAT_W.
- Hit: an accepted bit with fill ≥ PAT_W-1 and `{hist[PAT_W-2:0], data} == pat_reg`. The comparison uses `pat_reg` as it was before the edge.
- On a hit:
  - `match <= 1`.
  - If `overlap_en`=1, `fill` behaves normally, so a new detection can complete on the next accepted bit.
  - If `overlap_en`=0, `fill <= 0`; the next detection needs PAT_W fresh bits.
- `match <= 0` in every cycle without a hit. A cycle with `data_valid`=0 never holds or repeats a pulse.
- `pat_load`=1:
  - `pat_reg <= pat_in`, `fill <= 0`, `match <= 0`.
  - Any concurrent `data` is discarded; load wins over data.
- `data_valid`=0: `hist` and `fill` hold; bubbles between pattern bits are transparent.
- `overlap_en` may change at any time; it takes effect at the next hit.

## Timing
- Reset values: `pat_reg`=PAT_INIT, `hist`=0, `fill`=0, `match`=0, `match_cnt`=0.
- Reset asserted mid-sequence discards all partial history immediately (asynchronous).
- Latency: `match` is high in the cycle after the edge that accepted the final pattern bit, for exactly one cycle.
- Back-to-back hits, which are possible only with overlap, give `match` high in consecutive cycles.
- Pattern load takes effect for bits accepted from the cycle after `pat_load`.
- Combinational paths from input to `match` are not allowed.

## Configuration
- Macro `SD_PROG_MATCH_CNT_EN`.
- Defined:
  - `match_cnt` increments by 1 at each hit edge (same edge as `match` rising).
  - Saturates at 2^CNT_W-1.
  - `cnt_clr` forces 0; clear wins over a simultaneous hit.
- Undefined:
  - Counter logic is omitted.
  - `match_cnt` is constant 0.
  - `cnt_clr` is ignored.
  - Port list is unchanged.

## Test plan
- Reset, defaults, `overlap_en`=0, valid stream 0,1,1,0 → single `match` pulse the cycle after the 4th bit; `match_cnt`=1.
- Stream 0,1,1,0 with `data_valid`=0 bubbles of 1–3 cycles between bits → one pulse only, one cycle after the final accepted bit; no pulse during bubbles.
- `pat_load` with `pat_in`=4'b0101, stream 0,1,0,1,0,1 with `overlap_en`=1 → pulses after bits 4 and 6; with `overlap_en`=0 → pulse after bit 4 only.
- `pat_load` asserted together with `data_valid` mid-sequence → that bit is discarded, no match from the old pattern, and a fresh 4-bit match is required.
- `rst_n` pulsed low after 0,1,1, then 0 sent → no match; `match_cnt`=0.
- With macro defined and CNT_W=2: 5 matches → `match_cnt`=3 (saturated); `cnt_clr` on the same cycle as a hit → `match_cnt`=0. Without macro → `match_cnt` stays 0 throughout.

Source files
------------

// File: rtl/sd_prog.sv
// sd_prog: runtime-programmable serial sequence detector with overlap control.
// Latency: match is registered and pulses one cycle after the final pattern bit is accepted.
// Backpressure: none. Bits are taken whenever data_valid is high, and pat_load overrides data.
// Optional feature: define SD_PROG_MATCH_CNT_EN to build in the saturating match counter.
module sd_prog #(
  parameter int             PAT_W    = 4,
  parameter logic [PAT_W-1:0] PAT_INIT = 4'b0110,
  parameter int             CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data,
  input  logic             data_valid,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);
  localparam logic [FW-1:0] FILL_LAST = FW'(PAT_W - 1);

  // fill_q is the detector state: 0 = EMPTY, 1..PAT_W-1 = FILLING, PAT_W = ARMED
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             match_q, match_d;
  logic             accept;
  logic             hit;
  logic [PAT_W-1:0] window;

  // Hit decode: the incoming bit completes a window that equals the current pattern
  always_comb begin
    accept = data_valid && !pat_load;
    window = {hist_q[PAT_W-2:0], data};
    hit    = accept && (fill_q >= FILL_LAST) && (window == pat_q);
  end

  // Next-state logic: pattern load wins over data, a non-overlapping hit restarts collection
  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (pat_load) begin
      pat_d  = pat_in;
      fill_d = '0;
    end else if (data_valid) begin
      hist_d = window;
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + 1'b1;
      end
      if (hit) begin
        match_d = 1'b1;
        if (!overlap_en) begin
          fill_d = '0;
        end
      end
    end
  end

  // Detector state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= PAT_INIT;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match = match_q;

`ifdef SD_PROG_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating hit counter; a clear in the same cycle as a hit takes priority
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic unused_cnt_clr;

  // Counter not built: output is tied off and the clear input has no effect
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_sd_prog.sv
module tb_sd_prog;
  localparam int PAT_W = 4;
  localparam int CNT_W = 2;
  localparam logic [PAT_W-1:0] PAT_DEF = 4'b0110;
`ifdef SD_PROG_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             data;
  logic             data_valid;
  logic             overlap_en;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             cnt_clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the accepted bits since the last restart, the pattern and the count
  bit               m_bits[$];
  logic [PAT_W-1:0] m_pat;
  int               m_cnt;
  bit               m_match;

  sd_prog #(.PAT_W(PAT_W), .PAT_INIT(PAT_DEF), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .match(match), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive on the falling edge, predict, sample 1 ns after the rising edge
  task automatic step(input bit v, input bit d, input bit ld = 1'b0,
                      input logic [PAT_W-1:0] pin = '0, input bit clr = 1'b0);
    logic [PAT_W-1:0] w;
    bit hit;
    @(negedge clk);
    data_valid = v; data = d; pat_load = ld; pat_in = pin; cnt_clr = clr;
    hit = 1'b0;
    if (ld) begin
      m_pat = pin;
      m_bits.delete();
    end else if (v) begin
      m_bits.push_back(d);
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      if (m_bits.size() == PAT_W) begin
        w = '0;
        for (int i = 0; i < PAT_W; i++) w = {w[PAT_W-2:0], m_bits[i]};
        hit = (w == m_pat);
      end
      if (hit && !overlap_en) m_bits.delete();
    end
    m_match = hit;
    if (CNT_ON) begin
      if (clr) m_cnt = 0;
      else if (hit && m_cnt < CNT_MAX) m_cnt++;
    end
    @(posedge clk);
    #1;
    check("match", match, m_match);
    check("match_cnt", match_cnt, m_cnt);
  endtask

  // Asynchronous reset pulse landing between clock edges
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    m_bits.delete();
    m_pat = PAT_DEF;
    m_cnt = 0;
    m_match = 1'b0;
    check("rst_match", match, 1'b0);
    check("rst_cnt", match_cnt, 0);
    data_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0; data = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [PAT_W-1:0] bits);
    for (int i = PAT_W - 1; i >= 0; i--) step(1'b1, bits[i]);
  endtask

  initial begin
    rst_n = 1'b0; data = 1'b0; data_valid = 1'b0; overlap_en = 1'b0;
    pat_load = 1'b0; pat_in = '0; cnt_clr = 1'b0;
    m_pat = PAT_DEF; m_cnt = 0; m_match = 1'b0;
    #12;
    check("reset_match", match, 1'b0);
    check("reset_cnt", match_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default pattern, non-overlapping: one pulse right after the fourth bit
    step(1, 0); step(1, 1); step(1, 1);
    check("t1_before", match, 1'b0);
    step(1, 0);
    check("t1_pulse", match, 1'b1);
    check("t1_cnt", match_cnt, CNT_ON ? 1 : 0);
    step(0, 0);
    check("t1_one_cycle", match, 1'b0);

    // Bubbles of 1..3 cycles between bits are transparent
    step(1, 0); step(0, 1);
    step(1, 1); step(0, 0); step(0, 0);
    step(1, 1); step(0, 0); step(0, 1); step(0, 0);
    check("t2_bubble", match, 1'b0);
    step(1, 0);
    check("t2_pulse", match, 1'b1);
    step(0, 0);
    check("t2_hold", match, 1'b0);

    // Pattern 0101, overlapping: pulses after bits 4 and 6
    overlap_en = 1'b1;
    step(0, 0, 1, 4'b0101);
    step(1, 0); step(1, 1); step(1, 0); step(1, 1);
    check("t3_ov_first", match, 1'b1);
    step(1, 0);
    check("t3_ov_gap", match, 1'b0);
    step(1, 1);
    check("t3_ov_second", match, 1'b1);
    // Same pattern, non-overlapping: only after bit 4
    overlap_en = 1'b0;
    step(0, 0, 1, 4'b0101);
    step(1, 0); step(1, 1); step(1, 0); step(1, 1);
    check("t3_nov_first", match, 1'b1);
    step(1, 0); step(1, 1);
    check("t3_nov_none", match, 1'b0);

    // Load concurrent with valid data discards the bit and restarts collection
    step(0, 0, 1, PAT_DEF);
    step(1, 0); step(1, 1); step(1, 1);
    step(1, 0, 1, PAT_DEF);
    check("t4_load_discard", match, 1'b0);
    step(1, 0);
    check("t4_no_old", match, 1'b0);
    step(1, 1); step(1, 1); step(1, 0);
    check("t4_fresh", match, 1'b1);

    // Reset mid-sequence drops partial history
    step(1, 0); step(1, 1); step(1, 1);
    pulse_reset();
    step(1, 0);
    check("t5_no_match", match, 1'b0);
    check("t5_cnt", match_cnt, 0);

    // Counter saturation, then clear coinciding with a hit
    for (int k = 0; k < 5; k++) send(PAT_DEF);
    check("t6_sat", match_cnt, CNT_ON ? CNT_MAX : 0);
    step(1, 0); step(1, 1); step(1, 1);
    step(1, 0, 0, '0, 1);
    check("t6_clr_hit_match", match, 1'b1);
    check("t6_clr_wins", match_cnt, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) overlap_en = ~overlap_en;
      step($urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 49) == 0, PAT_W'($urandom),
           $urandom_range(0, 29) == 0);
      if (n == 1500) begin
        pulse_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
